l1i_bus_transform: RTL and testbench



---
 rtl/l1i_bus_transform.sv | 132 +++++++++++++
 tb/tb_l1i_bus_transform.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1i_bus_transform.sv
// Bus-side line transfer engine for the L1 instruction cache: moves a 128-bit
// line to or from the system bus as four 32-bit beats and pulses done to the cache FSM.
module l1i_bus_transform #(
    parameter int BEATS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        FSM_current_state,
    input  logic [31:0]       Core_CacheAddr,
    input  logic [31:0]       RAM_WbAddr,
    input  logic [127:0]      RAM_DataWrt,
    output logic              Transform_BusWrtDone,
    output logic              Transform_BusRdDone,
    output logic [127:0]      Transform_BusDataRdBuff,
    output logic              Bus_Req,
    output logic              Bus_We,
    output logic [ADDR_W-1:0] Bus_Addr,
    output logic [31:0]       Bus_WData,
    input  logic              Bus_Ack,
    input  logic [31:0]       Bus_RData
);
    localparam int BW = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [1:0] CS_WRITE = 2'b01;
    localparam logic [1:0] CS_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_BEAT, S_RD_BEAT, S_DONE_WR, S_DONE_RD, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        prev_q;
    logic [BW-1:0]     beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [127:0]      wbuf_q, wbuf_d;
    logic [127:0]      rbuf_q, rbuf_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              abort_q, abort_d;
    logic              wr_edge, rd_edge, leaving;

    // Line offset bits of both addresses are irrelevant to a line transfer.
    logic unused_offsets;
    assign unused_offsets = ^{Core_CacheAddr[3:0], RAM_WbAddr[3:0]};

    always_comb begin
        wr_edge   = (FSM_current_state == CS_WRITE) && (prev_q != CS_WRITE);
        rd_edge   = (FSM_current_state == CS_READ)  && (prev_q != CS_READ);
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        wbuf_d    = wbuf_q;
        rbuf_d    = rbuf_q;
        abort_d   = abort_q;
        wr_pend_d = wr_pend_q | wr_edge;
        rd_pend_d = rd_pend_q | rd_edge;
        leaving   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Starts seen while busy are honoured here only if the state still matches.
                wr_pend_d = 1'b0;
                rd_pend_d = 1'b0;
                abort_d   = 1'b0;
                if ((wr_edge || wr_pend_q) && FSM_current_state == CS_WRITE) begin
                    state_d = S_WR_BEAT;
                    wbuf_d  = RAM_DataWrt;
                    base_d  = {RAM_WbAddr[ADDR_W-1:4], 4'b0000};
                    beat_d  = '0;
                end else if ((rd_edge || rd_pend_q) && FSM_current_state == CS_READ) begin
                    state_d = S_RD_BEAT;
                    rbuf_d  = '0;
                    base_d  = {Core_CacheAddr[ADDR_W-1:4], 4'b0000};
                    beat_d  = '0;
                end
            end
            S_WR_BEAT, S_RD_BEAT: begin
                leaving = abort_q ||
                          (FSM_current_state != ((state_q == S_WR_BEAT) ? CS_WRITE : CS_READ));
                abort_d = leaving;
                if (Bus_Ack) begin
                    if (state_q == S_RD_BEAT) begin
                        rbuf_d[32*beat_q +: 32] = Bus_RData;
                    end
                    if (leaving) begin
                        state_d = S_DRAIN;
                    end else if (beat_q == LAST) begin
                        state_d = (state_q == S_WR_BEAT) ? S_DONE_WR : S_DONE_RD;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prev_q    <= 2'b00;
            beat_q    <= '0;
            rbuf_q    <= '0;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= FSM_current_state;
            beat_q    <= beat_d;
            rbuf_q    <= rbuf_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            abort_q   <= abort_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_d;
        wbuf_q <= wbuf_d;
    end

    // Bus outputs are decoded from registered state only and forced to zero outside a beat.
    assign Bus_Req                 = (state_q == S_WR_BEAT) || (state_q == S_RD_BEAT);
    assign Bus_We                  = (state_q == S_WR_BEAT);
    assign Bus_Addr                = Bus_Req ? (base_q + ADDR_W'({beat_q, 2'b00})) : '0;
    assign Bus_WData               = Bus_We ? wbuf_q[32*beat_q +: 32] : 32'h0;
    assign Transform_BusWrtDone    = (state_q == S_DONE_WR);
    assign Transform_BusRdDone     = (state_q == S_DONE_RD);
    assign Transform_BusDataRdBuff = rbuf_q;

endmodule

// File: tb/tb_l1i_bus_transform.sv
// Directed bench for l1i_bus_transform: a transaction-level beat/done scoreboard
// checked every cycle, plus literal expectations for addresses, latency and buffers.
module tb_l1i_bus_transform;
    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   FSM_current_state;
    logic [31:0]  Core_CacheAddr, RAM_WbAddr;
    logic [127:0] RAM_DataWrt;
    logic         Transform_BusWrtDone, Transform_BusRdDone;
    logic [127:0] Transform_BusDataRdBuff;
    logic         Bus_Req, Bus_We, Bus_Ack;
    logic [31:0]  Bus_Addr, Bus_WData, Bus_RData;
    logic [31:0]  rdata_base;
    int           stall_left, stall_beat;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { logic rd; logic [127:0] buff; } done_t;
    beat_t        exp_beats[$];
    done_t        exp_dones[$];
    logic [127:0] model_buf;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    // Bus slave returns base + word index, so every fill word is predictable.
    assign Bus_RData = rdata_base + {30'd0, Bus_Addr[3:2]};

    l1i_bus_transform #(.BEATS(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .FSM_current_state(FSM_current_state),
        .Core_CacheAddr(Core_CacheAddr), .RAM_WbAddr(RAM_WbAddr), .RAM_DataWrt(RAM_DataWrt),
        .Transform_BusWrtDone(Transform_BusWrtDone), .Transform_BusRdDone(Transform_BusRdDone),
        .Transform_BusDataRdBuff(Transform_BusDataRdBuff),
        .Bus_Req(Bus_Req), .Bus_We(Bus_We), .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData),
        .Bus_Ack(Bus_Ack), .Bus_RData(Bus_RData));

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask
    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask
    task automatic fail_unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual %h required nothing", name, act);
    endtask

    // Transaction model: a line transfer is nbeats word-aligned beats from the line base;
    // a complete transfer ends in one done whose buffer is the fill (or retained buffer).
    task automatic expect_xfer(input logic rd, input logic [31:0] addr, input logic [127:0] line,
                               input logic [31:0] rbase, input int nbeats);
        logic [31:0]  base;
        logic [127:0] fill;
        beat_t        b;
        done_t        d;
        base = {addr[31:4], 4'h0};
        fill = '0;
        for (int k = 0; k < nbeats; k++) begin
            b.addr  = base + 32'(4 * k);
            b.we    = !rd;
            b.wdata = rd ? 32'h0 : line[32*k +: 32];
            exp_beats.push_back(b);
            fill[32*k +: 32] = rbase + 32'(k);
        end
        if (rd) model_buf = fill;
        if (nbeats == 4) begin
            d.rd   = rd;
            d.buff = model_buf;
            exp_dones.push_back(d);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input logic rd, input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            step();
            n++;
            if (rd ? Transform_BusRdDone : Transform_BusWrtDone) return;
        end
        n = -1;
    endtask

    // Ack driver: normally always ready, withholds ack stall_left cycles on beat stall_beat.
    initial begin
        Bus_Ack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && Bus_Req && int'(Bus_Addr[3:2]) == stall_beat) begin
                Bus_Ack = 1'b0;
                stall_left--;
            end else begin
                Bus_Ack = 1'b1;
            end
        end
    end

    // Compare process: every accepted beat and every done pulse against the model.
    initial begin
        logic        prev_wait;
        logic [31:0] pa, pw;
        logic        pwe;
        beat_t       b;
        done_t       d;
        prev_wait = 1'b0;
        pa = '0; pw = '0; pwe = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_wait) begin
                chk1("hold_req", Bus_Req, 1'b1);
                chk32("hold_addr", Bus_Addr, pa);
                chk1("hold_we", Bus_We, pwe);
                chk32("hold_wdata", Bus_WData, pw);
            end
            prev_wait = 1'b0;
            if (Bus_Req && Bus_Ack) begin
                if (exp_beats.size() == 0) begin
                    fail_unexpected("beat_unexpected", Bus_Addr);
                end else begin
                    b = exp_beats.pop_front();
                    chk32("beat_addr", Bus_Addr, b.addr);
                    chk1("beat_we", Bus_We, b.we);
                    if (b.we) chk32("beat_wdata", Bus_WData, b.wdata);
                end
            end else if (Bus_Req && !rst) begin
                prev_wait = 1'b1;
                pa = Bus_Addr; pw = Bus_WData; pwe = Bus_We;
            end
            if (Transform_BusWrtDone || Transform_BusRdDone) begin
                chk1("done_exclusive", Transform_BusWrtDone & Transform_BusRdDone, 1'b0);
                chk1("req_low_in_done", Bus_Req, 1'b0);
                if (exp_dones.size() == 0) begin
                    fail_unexpected("done_unexpected", {30'd0, Transform_BusWrtDone, Transform_BusRdDone});
                end else begin
                    d = exp_dones.pop_front();
                    chk1("done_kind_rd", Transform_BusRdDone, d.rd);
                    chk128("done_buff", Transform_BusDataRdBuff, d.buff);
                end
            end
            if (rst) begin
                exp_beats.delete();
                exp_dones.delete();
                model_buf = '0;
                prev_wait = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; FSM_current_state = 2'b00; Core_CacheAddr = '0; RAM_WbAddr = '0;
        RAM_DataWrt = '0; rdata_base = '0; stall_left = 0; stall_beat = 0; model_buf = '0;
        step(3);
        chk1("rst_req", Bus_Req, 1'b0);
        chk1("rst_we", Bus_We, 1'b0);
        chk32("rst_addr", Bus_Addr, 32'h0);
        chk32("rst_wdata", Bus_WData, 32'h0);
        chk1("rst_wrdone", Transform_BusWrtDone, 1'b0);
        chk1("rst_rddone", Transform_BusRdDone, 1'b0);
        chk128("rst_buff", Transform_BusDataRdBuff, 128'h0);
        rst = 1'b0;
        step(2);

        // Read fill, ack always high
        Core_CacheAddr = 32'h0000_1234; rdata_base = 32'hA0;
        expect_xfer(1'b1, Core_CacheAddr, '0, rdata_base, 4);
        FSM_current_state = 2'b10;
        step(); chk1("t1_req", Bus_Req, 1'b1); chk1("t1_we", Bus_We, 1'b0);
        chk32("t1_addr0", Bus_Addr, 32'h1230);
        step(); chk32("t1_addr1", Bus_Addr, 32'h1234);
        step(); chk32("t1_addr2", Bus_Addr, 32'h1238);
        step(); chk32("t1_addr3", Bus_Addr, 32'h123C);
        step(); chk1("t1_done_at_5", Transform_BusRdDone, 1'b1);
        chk128("t1_buff", Transform_BusDataRdBuff, 128'h000000A3_000000A2_000000A1_000000A0);
        step(); chk1("t1_done_once", Transform_BusRdDone, 0);
        FSM_current_state = 2'b11; step();
        FSM_current_state = 2'b00; step(2);

        // Write-back; RAM data changes after the start to prove it was latched
        RAM_WbAddr = 32'h0000_2008;
        RAM_DataWrt = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        expect_xfer(1'b0, RAM_WbAddr, RAM_DataWrt, '0, 4);
        FSM_current_state = 2'b01;
        step(); chk1("t2_we", Bus_We, 1'b1); chk32("t2_addr0", Bus_Addr, 32'h2000);
        chk32("t2_wdata0", Bus_WData, 32'h11111111);
        RAM_DataWrt = {4{32'hDEADBEEF}};
        wait_done(1'b0, 10, n); chk32("t2_latency", n, 4);
        chk128("t2_buff_retained", Transform_BusDataRdBuff, 128'h000000A3_000000A2_000000A1_000000A0);
        FSM_current_state = 2'b00; step(2);

        // Write-back with ack withheld three cycles on beat 1
        RAM_WbAddr = 32'h0000_3004;
        RAM_DataWrt = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        stall_beat = 1; stall_left = 3;
        expect_xfer(1'b0, RAM_WbAddr, RAM_DataWrt, '0, 4);
        FSM_current_state = 2'b01;
        wait_done(1'b0, 20, n); chk32("t3_latency", n, 8);
        step(); chk1("t3_done_single", Transform_BusWrtDone, 1'b0);
        FSM_current_state = 2'b00; step(2);

        // Write immediately followed by read
        RAM_WbAddr = 32'h0000_4010; RAM_DataWrt = {32'h4, 32'h3, 32'h2, 32'h1};
        expect_xfer(1'b0, RAM_WbAddr, RAM_DataWrt, '0, 4);
        FSM_current_state = 2'b01;
        wait_done(1'b0, 10, n); chk32("t4_wr_latency", n, 5);
        chk1("t4_req_low_done", Bus_Req, 1'b0);
        step();
        chk1("t4_req_low_idle", Bus_Req, 1'b0);
        Core_CacheAddr = 32'h0000_5008; rdata_base = 32'hB0;
        expect_xfer(1'b1, Core_CacheAddr, '0, rdata_base, 4);
        FSM_current_state = 2'b10;
        step(); chk1("t4_rd_req", Bus_Req, 1'b1); chk32("t4_rd_addr0", Bus_Addr, 32'h5000);
        wait_done(1'b1, 10, n); chk32("t4_rd_latency", n, 4);
        FSM_current_state = 2'b11; step();
        FSM_current_state = 2'b00; step(2);

        // Read aborted during a stalled beat 2
        Core_CacheAddr = 32'h0000_6040; rdata_base = 32'hC0;
        stall_beat = 2; stall_left = 2;
        expect_xfer(1'b1, Core_CacheAddr, '0, rdata_base, 3);
        FSM_current_state = 2'b10;
        step(3); chk32("t5_addr2", Bus_Addr, 32'h6048);
        FSM_current_state = 2'b00;
        step(); chk1("t5_req_held", Bus_Req, 1'b1);
        step(); chk1("t5_req_held_ack", Bus_Req, 1'b1);
        step(); chk1("t5_drain_req", Bus_Req, 1'b0);
        step(); chk1("t5_idle_req", Bus_Req, 1'b0);
        step(8);
        chk128("t5_partial_buff", Transform_BusDataRdBuff, 128'h00000000_000000C2_000000C1_000000C0);

        // Reset during beat 1 of a read, then a normal fill
        Core_CacheAddr = 32'h0000_7000; rdata_base = 32'hD0;
        expect_xfer(1'b1, Core_CacheAddr, '0, rdata_base, 2);
        FSM_current_state = 2'b10;
        step(2); chk32("t6_addr1", Bus_Addr, 32'h7004);
        rst = 1'b1; FSM_current_state = 2'b00;
        step();
        chk1("t6_req", Bus_Req, 1'b0); chk32("t6_addr", Bus_Addr, 32'h0);
        chk1("t6_we", Bus_We, 1'b0); chk32("t6_wdata", Bus_WData, 32'h0);
        chk1("t6_rddone", Transform_BusRdDone, 1'b0);
        chk128("t6_buff", Transform_BusDataRdBuff, 128'h0);
        rst = 1'b0; step(2);
        rdata_base = 32'hE0;
        expect_xfer(1'b1, Core_CacheAddr, '0, rdata_base, 4);
        FSM_current_state = 2'b10;
        wait_done(1'b1, 10, n); chk32("t6_refill_latency", n, 5);
        chk128("t6_refill_buff", Transform_BusDataRdBuff, 128'h000000E3_000000E2_000000E1_000000E0);
        FSM_current_state = 2'b00; step(3);

        chk32("beats_left", exp_beats.size(), 0);
        chk32("dones_left", exp_dones.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
